// File: rtl/fir_run_ctrl_if.sv
// Response stream from the FIR run sequencer to its consumer (valid/ready handshake).
interface fir_run_ctrl_if #(
  parameter int DATA_W = 14
);
  logic signed [DATA_W-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_run_ctrl.sv
// Run sequencer for a FIR datapath: clears the filter, drives a generated stimulus and
// streams the responses over valid/ready, stalling the filter through its clock enable.
module fir_run_ctrl #(
  parameter int DATA_W       = 14,
  parameter int CNT_W        = 16,
  parameter int LATENCY      = 1,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     abort,
  input  logic [1:0]               mode,
  input  logic signed [DATA_W-1:0] amplitude,
  input  logic [CNT_W-1:0]         num_samples,
  output logic                     filt_clk_enable,
  output logic                     filt_reset,
  output logic signed [DATA_W-1:0] filt_in,
  input  logic signed [DATA_W-1:0] filt_out,
  fir_run_ctrl_if.master           out_if,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_t;

  localparam logic [1:0] MODE_IMPULSE = 2'd0;
  localparam logic [1:0] MODE_ALT     = 2'd2;
  localparam int         CLR_W        = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic signed [DATA_W-1:0] AMP_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] AMP_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  state_t                   state, state_n;
  logic [CLR_W-1:0]         clr_cnt;
  logic [CNT_W-1:0]         in_cnt, out_cnt, n_q;
  logic [2:0]               en_cnt;
  logic [1:0]               mode_q;
  logic signed [DATA_W-1:0] amp_q, amp_neg, stim;
  logic                     launch, valid, xfer;

  // Abort in IDLE also suppresses a simultaneous start.
  assign launch = (state == S_IDLE) && start && !abort;
  assign xfer   = valid && out_if.out_ready;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (launch) state_n = S_CLEAR;
      S_CLEAR: if (clr_cnt == CLR_W'(CLEAR_CYCLES - 1))
                 state_n = (n_q == '0) ? S_DONE : S_RUN;
      S_RUN:   if (xfer && out_cnt == n_q - CNT_W'(1)) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    if (abort) state_n = S_IDLE;
  end

  // Run parameters and counters; a transfer in an abort cycle still counts.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt <= '0;
      in_cnt  <= '0;
      out_cnt <= '0;
      en_cnt  <= '0;
      n_q     <= '0;
      mode_q  <= '0;
      amp_q   <= '0;
    end else begin
      case (state)
        S_IDLE: if (launch) begin
          mode_q  <= mode;
          amp_q   <= amplitude;
          n_q     <= num_samples;
          clr_cnt <= '0;
          in_cnt  <= '0;
          out_cnt <= '0;
          en_cnt  <= '0;
        end
        S_CLEAR: clr_cnt <= clr_cnt + CLR_W'(1);
        S_RUN: begin
          if (filt_clk_enable) begin
            if (in_cnt != n_q)          in_cnt <= in_cnt + CNT_W'(1);
            if (en_cnt != 3'(LATENCY))  en_cnt <= en_cnt + 3'd1;
          end
          if (xfer) out_cnt <= out_cnt + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Stimulus for sample index in_cnt; past N the zero drive flushes the filter latency.
  always_comb begin
    amp_neg = (amp_q == AMP_MIN) ? AMP_MAX : -amp_q;
    stim    = '0;
    if (mode_q == MODE_IMPULSE) begin
      if (in_cnt == '0) stim = amp_q;
    end else if (in_cnt < n_q) begin
      stim = (mode_q == MODE_ALT && in_cnt[0]) ? amp_neg : amp_q;
    end
  end

  // Output logic
  always_comb begin
    // NOTE: every output gets a default before the case so no path infers a latch.
    filt_clk_enable = 1'b0;
    filt_in         = '0;
    valid           = 1'b0;
    case (state)
      S_CLEAR: filt_clk_enable = 1'b1;
      S_RUN: begin
        valid           = (en_cnt == 3'(LATENCY)) && (out_cnt < n_q);
        filt_clk_enable = !valid || out_if.out_ready;
        filt_in         = stim;
      end
      default: ;
    endcase
  end

  assign filt_reset       = reset || (state == S_CLEAR);
  assign out_if.out_valid = valid;
  assign out_if.out_data  = filt_out;
  assign busy             = (state != S_IDLE);
  assign done             = (state == S_DONE);

endmodule
